// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Digits are scanned 0..3, each slot being a dead period (all anodes off)
// followed by an ON period. Writes land in shadow registers and are copied to
// the active set only at a frame boundary after a commit request.
module display_scan_ctrl #(
    parameter int unsigned P_ON_CYC   = 50000,
    parameter int unsigned P_DEAD_CYC = 500
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iWrEn,
    input  logic [1:0] iWrAddr,
    input  logic [3:0] iWrData,
    input  logic       iCommit,
    input  logic       iLzb,
    input  logic [3:0] iDigEn,
    output logic [3:0] oDigito,
    output logic [3:0] oAnodos,
    output logic       oFrameEnd,
    output logic       oBusy
);

    // One counter serves both phases, so it is sized for the longer one.
    localparam int unsigned CntMax = (P_ON_CYC > P_DEAD_CYC) ? P_ON_CYC : P_DEAD_CYC;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0] OnLast   = CntW'(P_ON_CYC - 1);
    localparam logic [CntW-1:0] DeadLast = CntW'(P_DEAD_CYC - 1);

    typedef enum logic [0:0] {StDead, StOn} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic            frame_end_q, frame_end_d;
    logic [3:0]      digito_q;
    logic [3:0]      anodos_q;
    logic [3:0]      anodos_lit;
    logic            pending_q;
    logic [3:0]      shadow_q [4];
    logic [3:0]      active_q [4];
    logic [3:0]      hi_zero;
    logic [3:0]      blank;
    logic            dead_done;
    logic            on_done;

    assign dead_done = (state_q == StDead) && (cnt_q == DeadLast);
    assign on_done   = (state_q == StOn) && (cnt_q == OnLast);

    // Next-state logic for the scan FSM, its counter and the digit index.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        idx_d   = idx_q;
        unique case (state_q)
            StDead: begin
                if (dead_done) begin
                    state_d = StOn;
                    cnt_d   = '0;
                end
            end
            StOn: begin
                if (on_done) begin
                    state_d = StDead;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                end
            end
            default: begin
                state_d = StDead;
                cnt_d   = '0;
            end
        endcase
        // Registered so the pulse coincides with the last ON cycle of digit 3.
        frame_end_d = (state_d == StOn) && (idx_d == 2'd3) && (cnt_d == OnLast);
    end

    // Leading-zero blanking and per-digit enable produce the anode pattern for the next slot.
    always_comb begin
        hi_zero[3] = (active_q[3] == 4'h0);
        hi_zero[2] = hi_zero[3] && (active_q[2] == 4'h0);
        hi_zero[1] = hi_zero[2] && (active_q[1] == 4'h0);
        hi_zero[0] = hi_zero[1] && (active_q[0] == 4'h0);
        blank      = {hi_zero[3:1], 1'b0} & {4{iLzb}};
        anodos_lit = 4'b1111;
        if (iDigEn[idx_q] && !blank[idx_q]) begin
            anodos_lit = ~(4'b0001 << idx_q);
        end
    end

    // Scan FSM state, counter, index and frame-end pulse.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q     <= StDead;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            frame_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            frame_end_q <= frame_end_d;
        end
    end

    // Digit nibble tracks the active value during DEAD; anodes latch only at slot edges.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            digito_q <= 4'h0;
            anodos_q <= 4'b1111;
        end else begin
            if (state_q == StDead) begin
                digito_q <= active_q[idx_q];
            end
            if (dead_done) begin
                anodos_q <= anodos_lit;
            end else if (on_done) begin
                anodos_q <= 4'b1111;
            end
        end
    end

    // Shadow writes, commit request and frame-synchronous copy to the active set.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            pending_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= 4'h0;
                active_q[i] <= 4'h0;
            end
        end else begin
            if (iWrEn) begin
                shadow_q[iWrAddr] <= iWrData;
            end
            if (frame_end_q && pending_q) begin
                pending_q <= 1'b0;
                for (int i = 0; i < 4; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end else if (iCommit) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign oDigito   = digito_q;
    assign oAnodos   = anodos_q;
    assign oFrameEnd = frame_end_q;
    assign oBusy     = pending_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed testbench for display_scan_ctrl with P_ON_CYC=4, P_DEAD_CYC=2 (24-cycle frame).
module tb_display_scan_ctrl;

    logic       iClk;
    logic       iReset;
    logic       iWrEn;
    logic [1:0] iWrAddr;
    logic [3:0] iWrData;
    logic       iCommit;
    logic       iLzb;
    logic [3:0] iDigEn;
    logic [3:0] oDigito;
    logic [3:0] oAnodos;
    logic       oFrameEnd;
    logic       oBusy;

    int n_cmp;
    int n_err;

    display_scan_ctrl #(
        .P_ON_CYC  (4),
        .P_DEAD_CYC(2)
    ) dut (
        .iClk     (iClk),
        .iReset   (iReset),
        .iWrEn    (iWrEn),
        .iWrAddr  (iWrAddr),
        .iWrData  (iWrData),
        .iCommit  (iCommit),
        .iLzb     (iLzb),
        .iDigEn   (iDigEn),
        .oDigito  (oDigito),
        .oAnodos  (oAnodos),
        .oFrameEnd(oFrameEnd),
        .oBusy    (oBusy)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        @(negedge iClk);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [3:0] data);
        iWrEn   = 1'b1;
        iWrAddr = addr;
        iWrData = data;
        step();
        iWrEn = 1'b0;
    endtask

    // Step to the first cycle of the next frame; optionally pulse iCommit in the frame-end cycle.
    task automatic sync_frame(input bit commit_at_fe);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (oFrameEnd) begin
                found = 1'b1;
                if (commit_at_fe) iCommit = 1'b1;
            end
            step();
            iCommit = 1'b0;
        end
        if (!found) check("sync_timeout", 32'd1, 32'd0);
    endtask

    // Called on cycle 1 of a frame; checks all 24 cycles and leaves on cycle 1 of the next frame.
    // an_exp/dig_exp pack digit 3..0 as {d3,d2,d1,d0}.
    task automatic check_frame(input string name, input logic [15:0] an_exp,
                               input logic [15:0] dig_exp, input logic exp_busy);
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 6; c++) begin
                if (c < 2) begin
                    check($sformatf("%s an s%0d c%0d", name, s, c), 32'(oAnodos), 32'hf);
                end else begin
                    check($sformatf("%s an s%0d c%0d", name, s, c), 32'(oAnodos),
                          32'(an_exp[s*4 +: 4]));
                    check($sformatf("%s dig s%0d c%0d", name, s, c), 32'(oDigito),
                          32'(dig_exp[s*4 +: 4]));
                end
                check($sformatf("%s fe s%0d c%0d", name, s, c), 32'(oFrameEnd),
                      32'((s == 3 && c == 5) ? 1 : 0));
                check($sformatf("%s busy s%0d c%0d", name, s, c), 32'(oBusy), 32'(exp_busy));
                step();
            end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        iReset  = 1'b1;
        iWrEn   = 1'b0;
        iWrAddr = 2'd0;
        iWrData = 4'h0;
        iCommit = 1'b0;
        iLzb    = 1'b0;
        iDigEn  = 4'b1111;

        // Reset state.
        repeat (3) @(negedge iClk);
        check("rst anodos", 32'(oAnodos), 32'hf);
        check("rst digito", 32'(oDigito), 32'h0);
        check("rst fe", 32'(oFrameEnd), 32'h0);
        check("rst busy", 32'(oBusy), 32'h0);

        // 1: plain scan, all zero.
        iReset = 1'b0;
        check_frame("t1", 16'h7BDE, 16'h0000, 1'b0);

        // 2: write 1,2,3,A and commit.
        wr(2'd0, 4'h1);
        wr(2'd1, 4'h2);
        wr(2'd2, 4'h3);
        wr(2'd3, 4'hA);
        iCommit = 1'b1;
        step();
        iCommit = 1'b0;
        check("t2 busy set", 32'(oBusy), 32'h1);
        sync_frame(1'b0);
        check("t2 busy clr", 32'(oBusy), 32'h0);
        check_frame("t2", 16'h7BDE, 16'hA321, 1'b0);

        // 3: active {0,0,7,0} with leading-zero blanking, then without.
        wr(2'd0, 4'h0);
        wr(2'd1, 4'h7);
        wr(2'd2, 4'h0);
        wr(2'd3, 4'h0);
        iCommit = 1'b1;
        step();
        iCommit = 1'b0;
        sync_frame(1'b0);
        iLzb = 1'b1;
        check_frame("t3lzb", 16'hFFDE, 16'h0070, 1'b0);
        iLzb = 1'b0;
        check_frame("t3nolzb", 16'h7BDE, 16'h0070, 1'b0);

        // 4: enable mask 0101.
        iDigEn = 4'b0101;
        check_frame("t4", 16'hFBFE, 16'h0070, 1'b0);
        iDigEn = 4'b1111;

        // 5: commit in the frame-end cycle applies one frame later.
        wr(2'd3, 4'h5);
        sync_frame(1'b1);
        check_frame("t5old", 16'h7BDE, 16'h0070, 1'b1);
        check_frame("t5new", 16'h7BDE, 16'h5070, 1'b0);

        // 6: reset mid-ON of digit 2 with a commit pending.
        iCommit = 1'b1;
        step();
        iCommit = 1'b0;
        repeat (13) step();
        check("t6 pre an", 32'(oAnodos), 32'hB);
        check("t6 pre busy", 32'(oBusy), 32'h1);
        iReset = 1'b1;
        #1;
        check("t6 rst an", 32'(oAnodos), 32'hF);
        check("t6 rst busy", 32'(oBusy), 32'h0);
        check("t6 rst dig", 32'(oDigito), 32'h0);
        @(negedge iClk);
        iReset = 1'b0;
        check_frame("t6", 16'h7BDE, 16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
